pc_fetch_sequencer: RTL and testbench
=====================================

Name: pc_fetch_sequencer

Overview:
- Owns the program counter register and the instruction-fetch handshake to instruction memory.
- Generates both next-PC candidates: sequential (pc+PC_INC) and branch target (pc+PC_INC+signed offset).
- Selects one on the branch flag from the execute stage and commits it once the datapath signals completion.
- Sits between instruction memory and the single-cycle datapath, and paces fetch/execute as a small FSM.

Parameters:
- PC_WIDTH, 8, program counter / instruction address width.
- INSTR_WIDTH, 16, instruction word width.
- RESET_PC, 8'h00, PC value loaded on reset.
- PC_INC, 1, sequential increment per instruction.

Ports:
- clk  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- run  input  1  level; starts fetching from IDLE.
- fetch_req  output  1  instruction memory request.
- fetch_addr  output  PC_WIDTH  address presented with fetch_req; always equals pc.
- fetch_ack  input  1  memory returns instr_in this cycle.
- instr_in  input  INSTR_WIDTH  fetched word.
- instr_out  output  INSTR_WIDTH  registered instruction to datapath.
- instr_valid  output  1  one-cycle pulse when instr_out is updated.
- exec_done  input  1  datapath finished the current instruction.
- branch  input  1  sampled with exec_done; 1 selects jumped_pc.
- branch_offset  input  PC_WIDTH  two's-complement offset, sampled with exec_done.
- halt  input  1  sampled with exec_done; stop after committing next PC.
- pc  output  PC_WIDTH  current PC register.
- added_pc  output  PC_WIDTH  combinational pc+PC_INC.
- jumped_pc  output  PC_WIDTH  combinational pc+PC_INC+branch_offset.
- halted  output  1  high in HALT state.

Behaviour:
- Reset (async, active-high): state=IDLE, pc=RESET_PC, instr_out=0, instr_valid=0, fetch_req=0, halted=0. Asserting reset mid-fetch drops fetch_req immediately, without waiting for a clock edge.
- IDLE: fetch_req=0. run=1 at an edge -> FETCH.
- FETCH: fetch_req=1, fetch_addr=pc.
  - fetch_ack=0: hold request and address stable, indefinitely.
  - fetch_ack=1 at an edge: instr_out<=instr_in, instr_valid=1 for the next cycle only, -> EXEC.
  - Minimum latency: 1 cycle req-to-ack, so instr_valid rises 2 edges after FETCH entry.
- EXEC: fetch_req=0.
  - On exec_done=1 at an edge: pc<=branch ? jumped_pc : added_pc. Then go to HALT if halt=1, else FETCH.
  - exec_done=0: hold; pc unchanged.
  - branch, branch_offset and halt are ignored when exec_done=0.
- HALT: halted=1, fetch_req=0. Exited only by reset. run, exec_done and fetch_ack are ignored.
- Arithmetic: all sums are truncated to PC_WIDTH (mod 2^PC_WIDTH); no overflow flag.
  - pc=8'hFF, no branch -> 8'h00.
  - Offset 8'hFE means -2, so pc=8'h05 branching gives 8'h04.
- Simultaneous events:
  - exec_done with halt: PC still commits before entering HALT.
  - fetch_ack outside FETCH: ignored.
  - run dropping during FETCH/EXEC: no effect; run is only sampled in IDLE.
- instr_valid is never high in two consecutive cycles.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE=2'd0, ST_FETCH=2'd1, ST_EXEC=2'd2, ST_HALT=2'd3;
  - PC_WIDTH and INSTR_WIDTH defaults;
  - RESET_PC.
- One natural combinational sub-module, pc_next_calc (inputs pc, branch_offset, branch; outputs added_pc, jumped_pc, next_pc). Keeping it separate lets it be unit-tested in isolation.
- FSM and registers stay in the top.

Test Plan:
- Reset then run=1, memory acks 1 cycle after req with 16'h1234 -> fetch_addr=8'h00, instr_out=16'h1234, single instr_valid pulse, state EXEC.
- exec_done=1, branch=0 from pc=8'h00 -> pc=8'h01, new fetch_req with fetch_addr=8'h01.
- pc=8'h05, exec_done=1, branch=1, offset=8'hFE -> pc=8'h04.
- pc=8'hFF, no branch -> pc=8'h00; pc=8'hF0, offset=8'h20, branch -> pc=8'h11.
- fetch_ack held low 5 cycles -> fetch_req and fetch_addr stable throughout, no instr_valid. Then reset asserted mid-wait -> fetch_req=0 before the next clock edge, pc=RESET_PC.
- exec_done=1 with halt=1, branch=0 at pc=8'h03 -> pc=8'h04, halted=1, no further fetch_req despite run=1 and fetch_ack toggling.

Source files
------------

// File: rtl/pc_fetch_sequencer_pkg.sv
// Shared definitions for the program-counter fetch sequencer:
// FSM state encoding plus default widths and reset address.
package pc_fetch_sequencer_pkg;

  localparam int PC_WIDTH_DEFAULT    = 8;
  localparam int INSTR_WIDTH_DEFAULT = 16;
  localparam int PC_INC_DEFAULT      = 1;

  localparam logic [PC_WIDTH_DEFAULT-1:0] RESET_PC_DEFAULT = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/pc_fetch_sequencer_pc_next_calc.sv
// Next-PC arithmetic: sequential and branch-target candidates and the
// selected one. All sums wrap modulo 2^PC_WIDTH; there is no overflow flag.
module pc_next_calc
  import pc_fetch_sequencer_pkg::*;
#(
  parameter int PC_WIDTH = PC_WIDTH_DEFAULT,
  parameter int PC_INC   = PC_INC_DEFAULT
) (
  input  logic [PC_WIDTH-1:0] pc,
  input  logic [PC_WIDTH-1:0] branch_offset,
  input  logic                branch,
  output logic [PC_WIDTH-1:0] added_pc,
  output logic [PC_WIDTH-1:0] jumped_pc,
  output logic [PC_WIDTH-1:0] next_pc
);

  // The offset is two's complement, so a plain wrapping add covers
  // backward branches without any sign extension.
  always_comb begin
    added_pc  = pc + PC_WIDTH'(PC_INC);
    jumped_pc = added_pc + branch_offset;
    next_pc   = branch ? jumped_pc : added_pc;
  end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Program counter owner and instruction-fetch pacer. A four-state FSM
// (IDLE, FETCH, EXEC, HALT) drives the memory request, latches the fetched
// word for the datapath and commits the next PC when execution completes.
module pc_fetch_sequencer
  import pc_fetch_sequencer_pkg::*;
#(
  parameter int                  PC_WIDTH    = PC_WIDTH_DEFAULT,
  parameter int                  INSTR_WIDTH = INSTR_WIDTH_DEFAULT,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = PC_WIDTH'(RESET_PC_DEFAULT),
  parameter int                  PC_INC      = PC_INC_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run,
  output logic                   fetch_req,
  output logic [PC_WIDTH-1:0]    fetch_addr,
  input  logic                   fetch_ack,
  input  logic [INSTR_WIDTH-1:0] instr_in,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic                   instr_valid,
  input  logic                   exec_done,
  input  logic                   branch,
  input  logic [PC_WIDTH-1:0]    branch_offset,
  input  logic                   halt,
  output logic [PC_WIDTH-1:0]    pc,
  output logic [PC_WIDTH-1:0]    added_pc,
  output logic [PC_WIDTH-1:0]    jumped_pc,
  output logic                   halted
);

  fetch_state_t        state;
  logic [PC_WIDTH-1:0] next_pc;

  pc_next_calc #(
    .PC_WIDTH (PC_WIDTH),
    .PC_INC   (PC_INC)
  ) u_pc_next_calc (
    .pc            (pc),
    .branch_offset (branch_offset),
    .branch        (branch),
    .added_pc      (added_pc),
    .jumped_pc     (jumped_pc),
    .next_pc       (next_pc)
  );

  // The fetch address is the PC itself so it stays stable while waiting.
  always_comb begin
    fetch_addr = pc;
  end

  // FSM with registered outputs; the async reset clears fetch_req at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      pc          <= RESET_PC;
      instr_out   <= '0;
      instr_valid <= 1'b0;
      fetch_req   <= 1'b0;
      halted      <= 1'b0;
    end else begin
      instr_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (run) begin
            state     <= ST_FETCH;
            fetch_req <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (fetch_ack) begin
            instr_out   <= instr_in;
            instr_valid <= 1'b1;
            fetch_req   <= 1'b0;
            state       <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (exec_done) begin
            pc <= next_pc;
            if (halt) begin
              state  <= ST_HALT;
              halted <= 1'b1;
            end else begin
              state     <= ST_FETCH;
              fetch_req <= 1'b1;
            end
          end
        end
        ST_HALT: begin
          halted    <= 1'b1;
          fetch_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed self-checking bench for pc_fetch_sequencer: fetch handshake,
// sequential and branch PC updates, wrap-around, stalled fetch, async reset
// during a fetch, and the halt state.
module tb_pc_fetch_sequencer;

  logic        clk;
  logic        reset;
  logic        run;
  logic        fetch_req;
  logic [7:0]  fetch_addr;
  logic        fetch_ack;
  logic [15:0] instr_in;
  logic [15:0] instr_out;
  logic        instr_valid;
  logic        exec_done;
  logic        branch;
  logic [7:0]  branch_offset;
  logic        halt;
  logic [7:0]  pc;
  logic [7:0]  added_pc;
  logic [7:0]  jumped_pc;
  logic        halted;

  int errors = 0;
  int checks = 0;

  pc_fetch_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .run           (run),
    .fetch_req     (fetch_req),
    .fetch_addr    (fetch_addr),
    .fetch_ack     (fetch_ack),
    .instr_in      (instr_in),
    .instr_out     (instr_out),
    .instr_valid   (instr_valid),
    .exec_done     (exec_done),
    .branch        (branch),
    .branch_offset (branch_offset),
    .halt          (halt),
    .pc            (pc),
    .added_pc      (added_pc),
    .jumped_pc     (jumped_pc),
    .halted        (halted)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic a, input logic [15:0] i,
                               input logic e, input logic b, input logic [7:0] o,
                               input logic h);
    run           = r;
    fetch_ack     = a;
    instr_in      = i;
    exec_done     = e;
    branch        = b;
    branch_offset = o;
    halt          = h;
  endtask

  task automatic stepClk();
    @(posedge clk);
    #1;
  endtask

  // Complete a FETCH with the given word, leaving the DUT in EXEC.
  task automatic doFetch(input logic [15:0] word);
    applyStimulus(1'b0, 1'b1, word, 1'b0, 1'b0, 8'h00, 1'b0);
    stepClk();
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  // Finish the current EXEC with the given branch decision.
  task automatic doExec(input logic b, input logic [7:0] o, input logic h);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, b, o, h);
    stepClk();
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    $display("[TB] starting pc_fetch_sequencer directed test");
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b0);
    #1;
    checkOutput("reset_pc", pc, 8'h00);
    checkOutput("reset_fetch_req", fetch_req, 1'b0);
    checkOutput("reset_instr_valid", instr_valid, 1'b0);
    checkOutput("reset_halted", halted, 1'b0);
    checkOutput("reset_instr_out", instr_out, 16'h0000);
    stepClk();
    reset = 1'b0;
    stepClk();
    checkOutput("idle_no_req", fetch_req, 1'b0);

    // Start fetching from address 0; memory answers one cycle later.
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b0);
    stepClk();
    checkOutput("fetch0_req", fetch_req, 1'b1);
    checkOutput("fetch0_addr", fetch_addr, 8'h00);
    checkOutput("fetch0_no_valid", instr_valid, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h1234, 1'b0, 1'b0, 8'h00, 1'b0);
    stepClk();
    checkOutput("fetch0_instr_out", instr_out, 16'h1234);
    checkOutput("fetch0_valid_pulse", instr_valid, 1'b1);
    checkOutput("exec0_req_low", fetch_req, 1'b0);

    // In EXEC: stray ack and branch without exec_done are ignored.
    applyStimulus(1'b0, 1'b1, 16'hBEEF, 1'b0, 1'b1, 8'h40, 1'b1);
    stepClk();
    checkOutput("valid_single_cycle", instr_valid, 1'b0);
    checkOutput("exec_ack_ignored", instr_out, 16'h1234);
    stepClk();
    checkOutput("exec_hold_pc", pc, 8'h00);
    checkOutput("exec_hold_req", fetch_req, 1'b0);
    checkOutput("added_pc_0", added_pc, 8'h01);
    checkOutput("jumped_pc_0", jumped_pc, 8'h41);

    // Sequential step 00 -> 01 and a new fetch at 01.
    doExec(1'b0, 8'h00, 1'b0);
    checkOutput("seq_pc_01", pc, 8'h01);
    checkOutput("seq_req", fetch_req, 1'b1);
    checkOutput("seq_addr_01", fetch_addr, 8'h01);

    // Forward branch 01 + 1 + 3 -> 05.
    doFetch(16'h0001);
    doExec(1'b1, 8'h03, 1'b0);
    checkOutput("branch_pc_05", pc, 8'h05);

    // Backward branch: offset FE is -2, 05 + 1 - 2 -> 04.
    doFetch(16'h0002);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 8'hFE, 1'b0);
    #1;
    checkOutput("jumped_pc_neg", jumped_pc, 8'h04);
    doExec(1'b1, 8'hFE, 1'b0);
    checkOutput("branch_pc_04", pc, 8'h04);

    // Reach FF (04 + 1 + FA), then wrap sequentially to 00.
    doFetch(16'h0003);
    doExec(1'b1, 8'hFA, 1'b0);
    checkOutput("branch_pc_ff", pc, 8'hFF);
    doFetch(16'h0004);
    doExec(1'b0, 8'h00, 1'b0);
    checkOutput("wrap_pc_00", pc, 8'h00);

    // Reach F0 (00 + 1 + EF), then branch +20 wraps to 11.
    doFetch(16'h0005);
    doExec(1'b1, 8'hEF, 1'b0);
    checkOutput("branch_pc_f0", pc, 8'hF0);
    doFetch(16'h0006);
    doExec(1'b1, 8'h20, 1'b0);
    checkOutput("branch_wrap_11", pc, 8'h11);

    // Stalled fetch: request and address hold, run drop has no effect.
    for (int k = 0; k < 5; k++) begin
      stepClk();
      checkOutput("stall_req", fetch_req, 1'b1);
      checkOutput("stall_addr", fetch_addr, 8'h11);
      checkOutput("stall_no_valid", instr_valid, 1'b0);
    end

    // Reset in mid-cycle must drop the request before the next edge.
    #3;
    reset = 1'b1;
    #1;
    checkOutput("async_reset_req", fetch_req, 1'b0);
    checkOutput("async_reset_pc", pc, 8'h00);
    #2;
    reset = 1'b0;
    stepClk();
    checkOutput("post_reset_idle", fetch_req, 1'b0);

    // Restart, go to 03, then halt with a sequential commit to 04.
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b0);
    stepClk();
    checkOutput("restart_addr", fetch_addr, 8'h00);
    doFetch(16'h0007);
    doExec(1'b1, 8'h02, 1'b0);
    checkOutput("pre_halt_pc_03", pc, 8'h03);
    doFetch(16'h0008);
    doExec(1'b0, 8'h00, 1'b1);
    checkOutput("halt_pc_04", pc, 8'h04);
    checkOutput("halt_flag", halted, 1'b1);
    checkOutput("halt_no_req", fetch_req, 1'b0);

    // HALT ignores run, acks and exec_done.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, k[0], 16'hAAAA, 1'b1, 1'b1, 8'h10, 1'b0);
      stepClk();
      checkOutput("halt_stays", halted, 1'b1);
      checkOutput("halt_req_low", fetch_req, 1'b0);
      checkOutput("halt_pc_hold", pc, 8'h04);
      checkOutput("halt_no_valid", instr_valid, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
